// File: rtl/pulse_train_pkg.sv
// ============================================================================
//  pulse_train_pkg -- shared state type and divider sizing helpers
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pulse_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Clock cycles per half period of the output wave.
  function automatic int CountValue(input int target_hz, input int base_hz);
    return base_hz / (2 * target_hz);
  endfunction

  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// ============================================================================
//  tick_divider -- free-running 0..MAXIMUM_VALUE-1 counter with wrap tick
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tick_divider
  import pulse_train_pkg::*;
#(
  parameter int MAXIMUM_VALUE     = 5,
  parameter int NBITS_FOR_COUNTER = CeilLog2(MAXIMUM_VALUE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  output logic                         tick,
  output logic [NBITS_FOR_COUNTER-1:0] CountOut
);

  localparam logic [NBITS_FOR_COUNTER-1:0] c_last_count =
    NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);

  logic [NBITS_FOR_COUNTER-1:0] count_q;
  logic [NBITS_FOR_COUNTER-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == c_last_count) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Clear outranks enable so an abort never produces a stray edge.
  assign tick     = enable && !clear && (count_q == c_last_count);
  assign CountOut = count_q;

endmodule

`default_nettype wire

// File: rtl/pulse_train_controller.sv
// ============================================================================
//  pulse_train_controller -- finite or continuous square-wave pulse trains
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_train_controller
  import pulse_train_pkg::*;
#(
  parameter int BASE_CLK          = 50000000,
  parameter int TARGET_FREQUENCY  = 100000,
  parameter int MAXIMUM_VALUE     = CountValue(TARGET_FREQUENCY, BASE_CLK),
  parameter int NBITS_FOR_COUNTER = CeilLog2(MAXIMUM_VALUE),
  parameter int NBITS_PULSES      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic [NBITS_PULSES-1:0] pulse_count,
  output logic                    wave,
  output logic                    busy,
  output logic                    done,
  output logic [NBITS_PULSES-1:0] periods_left
);

  if (MAXIMUM_VALUE < 2) begin : g_bad_maximum
    $error("pulse_train_controller: MAXIMUM_VALUE must be at least 2");
  end

  state_e                  state_q, state_d;
  logic                    wave_q, wave_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cont_q, cont_d;
  logic [NBITS_PULSES-1:0] left_q, left_d;

  logic                         div_clear;
  logic                         div_enable;
  logic                         tick;
  logic [NBITS_FOR_COUNTER-1:0] count_unused;

  assign div_enable = (state_q == ST_RUN);
  assign div_clear  = (state_q != ST_RUN) || stop;

  tick_divider #(
    .MAXIMUM_VALUE    (MAXIMUM_VALUE),
    .NBITS_FOR_COUNTER(NBITS_FOR_COUNTER)
  ) u_tick_divider (
    .clk     (clk),
    .reset   (reset),
    .clear   (div_clear),
    .enable  (div_enable),
    .tick    (tick),
    .CountOut(count_unused)
  );

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    left_d  = left_q;
    cont_d  = cont_q;
    case (state_q)
      ST_IDLE: begin
        wave_d = 1'b0;
        if (start && !stop) begin
          left_d  = pulse_count;
          cont_d  = continuous;
          state_d = ((pulse_count == '0) && !continuous) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          wave_d  = 1'b0;
          left_d  = '0;
        end else if (tick) begin
          wave_d = !wave_q;
          // A falling edge closes one full period of a finite train.
          if (wave_q && !cont_q) begin
            left_d = left_q - 1'b1;
            if (left_q == NBITS_PULSES'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        wave_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wave_d  = 1'b0;
        left_d  = '0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cont_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cont_q  <= cont_d;
      left_q  <= left_d;
    end
  end

  assign wave         = wave_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign periods_left = left_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_controller.sv
// ============================================================================
//  tb_pulse_train_controller -- directed and randomized pulse-train checks
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_train_controller;

  localparam int M = 5;  // half period in cycles at BASE_CLK=1000, 100 Hz

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] pulse_count;
  logic       wave;
  logic       busy;
  logic       done;
  logic [7:0] periods_left;

  int vectors;
  int miscompares;

  pulse_train_controller #(
    .BASE_CLK        (1000),
    .TARGET_FREQUENCY(100),
    .NBITS_PULSES    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .pulse_count (pulse_count),
    .wave        (wave),
    .busy        (busy),
    .done        (done),
    .periods_left(periods_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ew, input logic eb,
                           input logic ed, input logic [7:0] el);
    chk({tag, " wave"}, {7'd0, wave}, {7'd0, ew});
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, " done"}, {7'd0, done}, {7'd0, ed});
    chk({tag, " periods_left"}, periods_left, el);
  endtask

  // Expected outputs k cycles after the start edge, from the train's timing rules.
  function automatic void model(input int k, input int p, input bit cont, input int stop_at,
                                output logic w, output logic b, output logic d,
                                output logic [7:0] l);
    int t;
    t = 2 * M * p;
    w = 1'b0; b = 1'b0; d = 1'b0; l = 8'd0;
    if (stop_at >= 0 && k > stop_at) begin
      l = 8'd0;
    end else if (cont || k < t) begin
      b = 1'b1;
      w = ((k / M) % 2) == 1;
      l = cont ? 8'(p) : 8'(p - k / (2 * M));
    end else if (k == t) begin
      d = 1'b1;
    end
  endfunction

  task automatic run_train(input string name, input int p, input bit cont,
                           input int stop_at, input int ncycles, input bit noise);
    logic ew, eb, ed;
    logic [7:0] el;
    start = 1'b1; stop = 1'b0; continuous = cont; pulse_count = 8'(p);
    @(negedge clk);
    for (int k = 0; k < ncycles; k++) begin
      model(k, p, cont, stop_at, ew, eb, ed, el);
      check_all($sformatf("%s k=%0d", name, k), ew, eb, ed, el);
      stop = (k == stop_at);
      if (noise && (eb || ed)) begin
        start       = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        pulse_count = (k == 1) ? 8'd7 : 8'($urandom);
        continuous  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int p, sa, nc;
    bit c;
    vectors = 0; miscompares = 0;

    // Held in reset with start asserted: everything stays cleared.
    reset = 1'b0; start = 1'b1; stop = 1'b0; continuous = 1'b0; pulse_count = 8'd3;
    repeat (4) begin
      @(negedge clk);
      check_all("in_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_all("after_release", 1'b0, 1'b0, 1'b0, 8'd0);

    run_train("finite3", 3, 1'b0, -1, 33, 1'b0);
    run_train("zero_count", 0, 1'b0, -1, 3, 1'b0);
    run_train("cont_stop", 2, 1'b1, 23, 26, 1'b0);

    // start together with stop in IDLE is discarded.
    start = 1'b1; stop = 1'b1; pulse_count = 8'd5; continuous = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_all("start_with_stop", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    check_all("start_with_stop+1", 1'b0, 1'b0, 1'b0, 8'd0);

    run_train("restart_ignored", 2, 1'b0, -1, 23, 1'b1);

    // Asynchronous reset part-way through a three-period train.
    start = 1'b1; pulse_count = 8'd3; continuous = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      logic ew, eb, ed;
      logic [7:0] el;
      model(k, 3, 1'b0, -1, ew, eb, ed, el);
      check_all($sformatf("pre_reset k=%0d", k), ew, eb, ed, el);
      if (k < 12) @(negedge clk);
    end
    #1 reset = 1'b0;
    #1 check_all("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    check_all("reset_held", 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all("no_resume", 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Randomized trains with random aborts and start noise during RUN.
    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(1, 4));
      c = 1'($urandom_range(0, 1));
      if (c) begin
        sa = int'($urandom_range(3, 45));
      end else if ($urandom_range(0, 2) == 0) begin
        sa = int'($urandom_range(0, 2 * M * p - 1));
      end else begin
        sa = -1;
      end
      nc = (sa >= 0) ? sa + 3 : 2 * M * p + 3;
      run_train($sformatf("rand%0d p=%0d c=%0d s=%0d", i, p, c, sa), p, c, sa, nc, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
